// File: rtl/instr_loader_if.sv
// Loader-side bus: host byte stream in, instruction-memory write port and CPU
// control out.
interface instr_loader_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  start;
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic                  we;
    logic [DATA_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  cpu_hold;
    logic                  done;
    logic                  error;

    modport master (
        output start, rx_valid, rx_data,
        input  rx_ready, we, waddr, wdata, cpu_hold, done, error
    );

    modport slave (
        input  start, rx_valid, rx_data,
        output rx_ready, we, waddr, wdata, cpu_hold, done, error
    );
endinterface

// File: rtl/instr_loader.sv
// Boot-time program loader: assembles a length-prefixed little-endian byte
// stream into 32-bit words and writes them to instruction memory from address 0.
module instr_loader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    instr_loader_if.slave  ld_if
);
    localparam int unsigned IDX_W    = ADDR_WIDTH + 1;
    localparam int unsigned CAPACITY = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_DONE,
        S_ERR
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             byte_cnt_q, byte_cnt_d;
    logic [IDX_W-1:0]       word_idx_q, word_idx_d;
    logic [15:0]            n_q, n_d;
    logic [23:0]            asm_q, asm_d;
    logic                   rx_ready_q, rx_ready_d;
    logic                   we_q, we_d;
    logic [DATA_WIDTH-1:0]  waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic                   cpu_hold_q, cpu_hold_d;

    logic                   accept_c;
    logic [15:0]            hdr_n_c;
    logic                   last_word_c;

    assign accept_c    = ld_if.rx_valid && rx_ready_q;
    assign hdr_n_c     = {ld_if.rx_data, n_q[7:0]};
    assign last_word_c = (32'(word_idx_q) + 32'd1) == 32'(n_q);

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            n_q        <= '0;
            asm_q      <= '0;
            rx_ready_q <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cpu_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            n_q        <= n_d;
            asm_q      <= asm_d;
            rx_ready_q <= rx_ready_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            error_q    <= error_d;
            cpu_hold_q <= cpu_hold_d;
        end
    end

    // Next-state, counters and output next values.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        n_d        = n_q;
        asm_d      = asm_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (ld_if.start) begin
                    state_d    = S_HDR0;
                    byte_cnt_d = '0;
                    word_idx_d = '0;
                    n_d        = '0;
                    asm_d      = '0;
                end
            end
            S_HDR0: begin
                if (accept_c) begin
                    n_d     = {8'h00, ld_if.rx_data};
                    state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                if (accept_c) begin
                    n_d = hdr_n_c;
                    if (hdr_n_c == 16'd0) begin
                        state_d = S_DONE;
                    end else if (32'(hdr_n_c) > CAPACITY) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept_c) begin
                    // Bytes enter at the top so the first byte lands in [7:0].
                    asm_d      = {ld_if.rx_data, asm_q[23:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        we_d       = 1'b1;
                        wdata_d    = {ld_if.rx_data, asm_q};
                        waddr_d    = DATA_WIDTH'({word_idx_q, 2'b00});
                        word_idx_d = word_idx_q + IDX_W'(1);
                        if (last_word_c) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        rx_ready_d = (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_DATA);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
        // Release lags DONE by a cycle so the final write lands before any fetch.
        cpu_hold_d = !((state_q == S_DONE) && (state_d == S_DONE));
    end

    assign ld_if.rx_ready = rx_ready_q;
    assign ld_if.we       = we_q;
    assign ld_if.waddr    = waddr_q;
    assign ld_if.wdata    = wdata_q;
    assign ld_if.done     = done_q;
    assign ld_if.error    = error_q;
    assign ld_if.cpu_hold = cpu_hold_q;
endmodule
